mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store unit on the downstream side of the EX stage. Consumes EX-stage memory-control outputs (read/write strobes, func3, ALU-computed address, rs2 store data), runs a REQ/ACK transaction on the data-memory bus, and returns sign- or zero-extended load data. Holds `MEM_STALL` high to freeze the pipeline until the access completes.

## Interface
- `ADDR_WIDTH`, default 32: width of `EX_ADDRESS` and `BUS_ADDR`.
- `CLK` in 1: clock; all state on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `EX_MEM_READ` in 1: load request.
- `EX_MEM_WRITE` in 1: store request; has priority over `EX_MEM_READ` when both are high.
- `EX_FUNC3` in 3: access size and sign. 000 B, 001 H, 010 W, 100 BU, 101 HU. Any other value is treated as W.
- `EX_ADDRESS` in ADDR_WIDTH: byte address (ALU result).
- `EX_WRITE_DATA` in 32: store data (rs2).
- `MEM_STALL` out 1: pipeline freeze; combinational.
- `MEM_READ_DATA` out 32: extended load result; valid only while `MEM_DATA_VALID` is high.
- `MEM_DATA_VALID` out 1: one-cycle pulse marking a completed load.
- `MEM_MISALIGNED` out 1: one-cycle pulse marking a misaligned access.
- `BUS_REQ` out 1: bus request.
- `BUS_WE` out 1: bus write enable.
- `BUS_ADDR` out ADDR_WIDTH: word-aligned address; bits [1:0] are always 0.
- `BUS_WDATA` out 32: lane-replicated store data.
- `BUS_BYTE_EN` out 4: byte-lane enables.
- `BUS_ACK` in 1: memory completion.
- `BUS_RDATA` in 32: read word; sampled only in the cycle `BUS_ACK` is high.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no request pending (no `EX_MEM_WRITE` or `EX_MEM_READ`): stay in IDLE.
- IDLE, request pending:
  - Latch address, func3, write data and write-enable.
  - `MEM_STALL` goes high in that same cycle.
  - Next state is ACCESS. With `MEM_MISALIGN_TRAP_EN` defined and the access misaligned, next state is DONE instead.
- ACCESS:
  - `BUS_REQ` is high; all `BUS_*` outputs are registered and held stable.
  - `MEM_STALL` is high.
  - `BUS_ACK` high: capture `BUS_RDATA` and go to DONE.
  - `BUS_ACK` low: stay in ACCESS. There is no timeout.
- DONE:
  - `MEM_STALL` is low, so the pipeline advances at the end of this cycle.
  - Load: `MEM_DATA_VALID` is 1.
  - New requests are ignored, because the inputs still show the completed instruction.
  - Next state is always IDLE.
- Byte lanes use the latched `addr[1:0]`:
  - B: `BUS_BYTE_EN = 1 << addr[1:0]`; `BUS_WDATA = {4{wdata[7:0]}}`.
  - H: `BUS_BYTE_EN = 0011 << {addr[1],1'b0}`; `BUS_WDATA = {2{wdata[15:0]}}`.
  - W: `BUS_BYTE_EN = 1111`; `BUS_WDATA = wdata`.
- Load extension:
  - The selected lane is right-justified.
  - B and H are sign-extended from bit 7 or bit 15.
  - BU and HU are zero-extended.
- `BUS_ACK` outside ACCESS is ignored.
- `BUS_RDATA` is ignored on stores; `MEM_READ_DATA` holds its last value.

## Timing
- Reset (`RST` high at an edge), from the following cycle:
  - State is IDLE.
  - `BUS_REQ`, `BUS_WE`, `BUS_ADDR`, `BUS_WDATA`, `BUS_BYTE_EN`, `MEM_READ_DATA`, `MEM_DATA_VALID`, `MEM_MISALIGNED` are all 0.
  - `MEM_STALL` is 0 unless a request is pending in IDLE.
- Reset mid-ACCESS aborts the transaction: `BUS_REQ` drops on the next cycle and an ACK arriving later is ignored.
- Minimum latency, for a request seen in IDLE at cycle T:
  - T+1: ACCESS with `BUS_REQ` high.
  - `BUS_ACK` high at T+1: DONE at T+2.
  - `MEM_STALL` is high for exactly cycles T and T+1.
- Each wait cycle of `BUS_ACK` adds one ACCESS cycle and one stall cycle.
- Back-to-back accesses: the next request is accepted in the IDLE cycle after DONE, so the throughput floor is 3 cycles per access.
- Read and write strobes both high: one write transaction is performed and no load data is produced.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - H with `addr[0]=1`, or W with `addr[1:0]!=0`, issues no bus transaction.
  - Stall lasts 1 cycle (IDLE), then DONE with `MEM_MISALIGNED=1` and `MEM_DATA_VALID=0`.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - `MEM_MISALIGNED` is tied 0.
  - Offending low address bits are ignored: H uses `addr[1]`, W uses lane 0, and the access proceeds normally.

## Test plan
- **LB, no wait:** LB at address 0x103, `BUS_RDATA=0x80112233`, ACK at the first REQ cycle → `BUS_BYTE_EN=1000`, `BUS_ADDR=0x100`, `MEM_READ_DATA=0xFFFFFF80` with `MEM_DATA_VALID` at T+2, stall high for 2 cycles.
- **SH, 3 wait states:** SH at 0x202 with data 0x0000ABCD, ACK after 3 wait cycles → `BUS_WE=1`, `BUS_BYTE_EN=1100`, `BUS_WDATA=0xABCDABCD`, `BUS_*` stable, stall high for 5 cycles, no `MEM_DATA_VALID`.
- **LHU and LW:** LHU at 0x0 with `BUS_RDATA=0x1234F00D` → `0x0000F00D`; LW at 0x4 → full word returned unchanged.
- **Both strobes high, back-to-back:** read and write high together → one write only; a second request presented in DONE is not launched until the next IDLE.
- **Reset mid-access:** `RST` pulsed during ACCESS → `BUS_REQ=0` the next cycle; a later ACK produces no `MEM_DATA_VALID`.
- **Misaligned LW:** LW at 0x6 → with the macro, no `BUS_REQ`, `MEM_MISALIGNED` 1-cycle pulse, stall 1 cycle; without the macro, `BUS_ADDR=0x4`, `BYTE_EN=1111`.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store unit behind the EX stage. It latches one memory request,
//   runs a single REQ/ACK transaction on the data bus and returns
//   right-justified, sign- or zero-extended load data. MEM_STALL holds the
//   pipeline until the access has completed.
//
//   Optional feature macro: MEM_MISALIGN_TRAP_EN
//     defined   : a misaligned H/W access skips the bus and pulses MEM_MISALIGNED
//     undefined : the offending low address bits are ignored, MEM_MISALIGNED = 0
//
//   Ports
//     CLK, RST          clock; synchronous active-high reset
//     EX_MEM_READ/WRITE load / store strobes (the store wins when both are high)
//     EX_FUNC3          000 B, 001 H, 010 W, 100 BU, 101 HU; any other value is W
//     EX_ADDRESS        byte address
//     EX_WRITE_DATA     store data (rs2)
//     MEM_STALL         pipeline freeze (combinational)
//     MEM_READ_DATA     extended load result
//     MEM_DATA_VALID    one-cycle pulse for a completed load
//     MEM_MISALIGNED    one-cycle pulse for a trapped misaligned access
//     BUS_*             registered data-memory bus: REQ, WE, ADDR, WDATA,
//                       BYTE_EN out; ACK, RDATA in
//
//   state  | meaning
//   IDLE   | waiting for a request; latches it and stalls in the same cycle
//   ACCESS | BUS_REQ high, waiting for BUS_ACK
//   DONE   | stall released; load data valid; incoming requests ignored
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EX_MEM_READ,
  input  logic                  EX_MEM_WRITE,
  input  logic [2:0]            EX_FUNC3,
  input  logic [ADDR_WIDTH-1:0] EX_ADDRESS,
  input  logic [31:0]           EX_WRITE_DATA,
  output logic                  MEM_STALL,
  output logic [31:0]           MEM_READ_DATA,
  output logic                  MEM_DATA_VALID,
  output logic                  MEM_MISALIGNED,
  output logic                  BUS_REQ,
  output logic                  BUS_WE,
  output logic [ADDR_WIDTH-1:0] BUS_ADDR,
  output logic [31:0]           BUS_WDATA,
  output logic [3:0]            BUS_BYTE_EN,
  input  logic                  BUS_ACK,
  input  logic [31:0]           BUS_RDATA
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state, state_nxt;
  logic                  accept;
  logic                  trap_in;
  logic                  is_byte, is_half;
  logic [3:0]            be_in;
  logic [31:0]           wdata_in;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            func3_q;
  logic                  we_q;
  logic [31:0]           load_ext;
  logic [31:0]           rd_shift;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;

  // func3[1:0] alone selects the size; 011/110/111 fall through to word.
  assign is_byte = (EX_FUNC3[1:0] == 2'b00);
  assign is_half = (EX_FUNC3[1:0] == 2'b01);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_in = (is_half & EX_ADDRESS[0]) |
                   (~is_byte & ~is_half & (EX_ADDRESS[1:0] != 2'b00));
`else
  assign trap_in = 1'b0;
`endif

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = EX_WRITE_DATA;
    if (is_byte) begin
      be_in    = 4'b0001 << EX_ADDRESS[1:0];
      wdata_in = {4{EX_WRITE_DATA[7:0]}};
    end else if (is_half) begin
      be_in    = 4'b0011 << {EX_ADDRESS[1], 1'b0};
      wdata_in = {2{EX_WRITE_DATA[15:0]}};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    MEM_STALL = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (EX_MEM_READ || EX_MEM_WRITE) begin
          MEM_STALL = 1'b1;
          accept    = 1'b1;
          state_nxt = trap_in ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        MEM_STALL = 1'b1;
        if (BUS_ACK) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane selection uses the latched address; word loads always take lane 0.
  assign rd_shift = BUS_RDATA >> {addr_q[1:0], 3'b000};
  assign rd_byte  = rd_shift[7:0];
  assign rd_half  = addr_q[1] ? BUS_RDATA[31:16] : BUS_RDATA[15:0];

  always_comb begin
    case (func3_q)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_ext = {24'd0, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_ext = {16'd0, rd_half};
      default: load_ext = BUS_RDATA;
    endcase
  end

  assign BUS_ADDR = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q         <= '0;
      func3_q        <= '0;
      we_q           <= 1'b0;
      BUS_REQ        <= 1'b0;
      BUS_WE         <= 1'b0;
      BUS_WDATA      <= '0;
      BUS_BYTE_EN    <= '0;
      MEM_READ_DATA  <= '0;
      MEM_DATA_VALID <= 1'b0;
    end else begin
      MEM_DATA_VALID <= 1'b0;
      if (accept) begin
        addr_q  <= EX_ADDRESS;
        func3_q <= EX_FUNC3;
        we_q    <= EX_MEM_WRITE;
        if (!trap_in) begin
          BUS_REQ     <= 1'b1;
          BUS_WE      <= EX_MEM_WRITE;
          BUS_WDATA   <= wdata_in;
          BUS_BYTE_EN <= be_in;
        end
      end
      if (state == ACCESS && BUS_ACK) begin
        BUS_REQ <= 1'b0;
        BUS_WE  <= 1'b0;
        if (!we_q) begin
          MEM_READ_DATA  <= load_ext;
          MEM_DATA_VALID <= 1'b1;
        end
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge CLK) begin
    if (RST) MEM_MISALIGNED <= 1'b0;
    else     MEM_MISALIGNED <= accept & trap_in;
  end
`else
  assign MEM_MISALIGNED = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Directed and randomized accesses against a transaction-level model of
//   mem_access_unit. Build with +define+MEM_MISALIGN_TRAP_EN to cover the
//   misaligned-trap configuration.
module tb_mem_access_unit;

  localparam int AW = 32;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic          EX_MEM_READ, EX_MEM_WRITE;
  logic [2:0]    EX_FUNC3;
  logic [AW-1:0] EX_ADDRESS;
  logic [31:0]   EX_WRITE_DATA;
  logic          MEM_STALL;
  logic [31:0]   MEM_READ_DATA;
  logic          MEM_DATA_VALID, MEM_MISALIGNED;
  logic          BUS_REQ, BUS_WE;
  logic [AW-1:0] BUS_ADDR;
  logic [31:0]   BUS_WDATA;
  logic [3:0]    BUS_BYTE_EN;
  logic          BUS_ACK;
  logic [31:0]   BUS_RDATA;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_rd;

  always #5 CLK = ~CLK;

  mem_access_unit #(.ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST),
    .EX_MEM_READ(EX_MEM_READ), .EX_MEM_WRITE(EX_MEM_WRITE),
    .EX_FUNC3(EX_FUNC3), .EX_ADDRESS(EX_ADDRESS), .EX_WRITE_DATA(EX_WRITE_DATA),
    .MEM_STALL(MEM_STALL), .MEM_READ_DATA(MEM_READ_DATA),
    .MEM_DATA_VALID(MEM_DATA_VALID), .MEM_MISALIGNED(MEM_MISALIGNED),
    .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
    .BUS_WDATA(BUS_WDATA), .BUS_BYTE_EN(BUS_BYTE_EN),
    .BUS_ACK(BUS_ACK), .BUS_RDATA(BUS_RDATA)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // ---- reference model: access rules written as arithmetic ----
  function automatic int size_of(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int offset_of(input logic [2:0] f, input logic [31:0] a);
    int sz = size_of(f);
    if (sz == 4) return 0;
    if (sz == 2) return int'(a % 4) & 2;
    return int'(a % 4);
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f, input logic [31:0] a);
    int v = ((1 << size_of(f)) - 1) << offset_of(f, a);
    return v[3:0];
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f, input logic [31:0] w);
    int sz = size_of(f);
    if (sz == 1) return (w % 256) * 32'h0101_0101;
    if (sz == 2) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] r);
    int sz = size_of(f);
    logic [31:0] mask, lane;
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    lane = (r >> (8 * offset_of(f, a))) & mask;
    if (sz < 4 && f[2] == 1'b0 && lane[8 * sz - 1]) lane = lane | ~mask;
    return lane;
  endfunction

  function automatic bit misal(input logic [2:0] f, input logic [31:0] a);
    int sz = size_of(f);
    return (sz == 2 && (a % 2) != 0) || (sz == 4 && (a % 4) != 0);
  endfunction

  // Runs one access from its request cycle T to its DONE cycle and returns
  // with the DUT in DONE and the strobes still showing the instruction.
  // in_done: called while the DUT is in DONE of the previous access.
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdat, input int waits, input bit in_done);
    bit is_load = rd && !wr;
    bit trap    = TRAP && misal(f, a);
    int stalls  = 0;
    EX_MEM_READ   = rd;
    EX_MEM_WRITE  = wr;
    EX_FUNC3      = f;
    EX_ADDRESS    = a;
    EX_WRITE_DATA = wd;
    BUS_ACK       = 1'($urandom % 2);
    BUS_RDATA     = $urandom;
    #1;
    if (in_done) begin
      chk("done_req_ignored_stall", 32'(MEM_STALL), 0);
      chk("done_req_ignored_busreq", 32'(BUS_REQ), 0);
      step();
      BUS_ACK = 1'($urandom % 2);
    end
    chk("req_cycle_stall", 32'(MEM_STALL), 1);
    chk("req_cycle_busreq", 32'(BUS_REQ), 0);
    if (MEM_STALL) stalls++;
    if (!trap) begin
      for (int i = 0; i <= waits; i++) begin
        step();
        chk("acc_stall", 32'(MEM_STALL), 1);
        chk("acc_busreq", 32'(BUS_REQ), 1);
        chk("acc_buswe", 32'(BUS_WE), 32'(wr));
        chk("acc_busaddr", BUS_ADDR, a & 32'hFFFF_FFFC);
        chk("acc_byteen", 32'(BUS_BYTE_EN), 32'(exp_be(f, a)));
        if (wr) chk("acc_wdata", BUS_WDATA, exp_wd(f, wd));
        chk("acc_valid", 32'(MEM_DATA_VALID), 0);
        if (MEM_STALL) stalls++;
        BUS_ACK   = (i == waits);
        BUS_RDATA = (i == waits) ? rdat : $urandom;
      end
    end
    step();
    BUS_ACK   = 1'($urandom % 2);
    BUS_RDATA = $urandom;
    if (MEM_STALL) stalls++;
    chk("done_stall", 32'(MEM_STALL), 0);
    chk("done_busreq", 32'(BUS_REQ), 0);
    chk("done_valid", 32'(MEM_DATA_VALID), 32'(is_load && !trap));
    chk("done_misaligned", 32'(MEM_MISALIGNED), 32'(trap));
    if (is_load && !trap) last_rd = exp_rd(f, a, rdat);
    chk("done_rdata", MEM_READ_DATA, last_rd);
    chk("stall_cycles", stalls, trap ? 1 : waits + 2);
  endtask

  task automatic go_idle();
    EX_MEM_READ  = 1'b0;
    EX_MEM_WRITE = 1'b0;
    BUS_ACK      = 1'($urandom % 2);
    step();
    BUS_ACK = 1'b0;
    #1;
    chk("idle_stall", 32'(MEM_STALL), 0);
    chk("idle_busreq", 32'(BUS_REQ), 0);
    chk("idle_valid", 32'(MEM_DATA_VALID), 0);
    chk("idle_misaligned", 32'(MEM_MISALIGNED), 0);
  endtask

  initial begin
    bit          rd, wr, b2b;
    logic [2:0]  f;
    RST = 1'b1;
    EX_MEM_READ = 1'b0; EX_MEM_WRITE = 1'b0;
    EX_FUNC3 = 3'b000; EX_ADDRESS = '0; EX_WRITE_DATA = '0;
    BUS_ACK = 1'b0; BUS_RDATA = '0;
    last_rd = 32'd0;
    step();
    step();
    chk("rst_busreq", 32'(BUS_REQ), 0);
    chk("rst_buswe", 32'(BUS_WE), 0);
    chk("rst_busaddr", BUS_ADDR, 0);
    chk("rst_wdata", BUS_WDATA, 0);
    chk("rst_byteen", 32'(BUS_BYTE_EN), 0);
    chk("rst_rdata", MEM_READ_DATA, 0);
    chk("rst_valid", 32'(MEM_DATA_VALID), 0);
    chk("rst_misaligned", 32'(MEM_MISALIGNED), 0);
    chk("rst_stall_idle", 32'(MEM_STALL), 0);
    EX_MEM_READ = 1'b1;
    #1;
    chk("rst_stall_pending", 32'(MEM_STALL), 1);
    EX_MEM_READ = 1'b0;
    RST = 1'b0;
    step();

    // LB, no wait
    do_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h8011_2233, 0, 0);
    chk("lb_const_rdata", MEM_READ_DATA, 32'hFFFF_FF80);
    go_idle();
    // SH, 3 wait states
    do_access(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 32'hDEAD_BEEF, 3, 0);
    go_idle();
    // LHU, LW
    do_access(1, 0, 3'b101, 32'h0, 32'h0, 32'h1234_F00D, 0, 0);
    chk("lhu_const_rdata", MEM_READ_DATA, 32'h0000_F00D);
    go_idle();
    do_access(1, 0, 3'b010, 32'h4, 32'h0, 32'hCAFE_1234, 1, 0);
    go_idle();
    // both strobes, then a request presented in DONE
    do_access(1, 1, 3'b010, 32'h10, 32'h5555_AAAA, 32'h1111_2222, 1, 0);
    do_access(1, 0, 3'b000, 32'h21, 32'h0, 32'h0000_8000, 0, 1);
    go_idle();

    // reset in the middle of an access
    EX_MEM_READ = 1'b1; EX_FUNC3 = 3'b010; EX_ADDRESS = 32'h8;
    step();
    chk("rmid_busreq_before", 32'(BUS_REQ), 1);
    RST = 1'b1;
    EX_MEM_READ = 1'b0;
    step();
    RST = 1'b0;
    chk("rmid_busreq_after", 32'(BUS_REQ), 0);
    chk("rmid_stall_after", 32'(MEM_STALL), 0);
    BUS_ACK = 1'b1; BUS_RDATA = 32'h7777_7777;
    step();
    BUS_ACK = 1'b0;
    chk("rmid_late_ack_valid", 32'(MEM_DATA_VALID), 0);
    chk("rmid_late_ack_busreq", 32'(BUS_REQ), 0);
    chk("rmid_rdata", MEM_READ_DATA, 0);
    last_rd = 32'd0;
    step();

    // misaligned word and half loads
    do_access(1, 0, 3'b010, 32'h6, 32'h0, 32'h89AB_CDEF, 0, 0);
    go_idle();
    do_access(1, 0, 3'b001, 32'h3, 32'h0, 32'h8001_0203, 1, 0);
    go_idle();

    // randomized accesses, some presented back-to-back from DONE
    for (int i = 0; i < 60; i++) begin
      rd  = 1'($urandom % 2);
      wr  = rd ? 1'($urandom % 2) : 1'b1;
      f   = 3'($urandom % 8);
      b2b = (i > 0) && ($urandom % 3 == 0);
      if (i > 0 && !b2b) go_idle();
      do_access(rd, wr, f, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)), b2b);
    end
    go_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
